// File: rtl/goe_eval_sched.sv
// Round-robin time-multiplexer for one shared gen_goe_lut tree; result SETTLE+1 cycles after accept.
// Backpressure: req_ready pulses only when idle and en is high; requesters hold req_valid/req_mask until then.
module goe_eval_sched #(
   parameter int NREQ   = 2,
   parameter int SETTLE = 2,
   localparam int GW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*256-1:0]   req_mask,
   output logic [NREQ-1:0]       req_ready,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [1:0]            rsp_goe,
   output logic [255:0]          lut_a,
   input  logic [1:0]            lut_spo,
   output logic                  busy,
   output logic [GW-1:0]         grant_id
);

   localparam int S_EFF = (SETTLE < 1) ? 1 : SETTLE;
   localparam int CW    = (S_EFF > 1) ? $clog2(S_EFF) : 1;

   typedef enum logic {ST_IDLE, ST_SETTLE} state_t;

   state_t          state, state_nxt;
   logic [GW-1:0]   last;
   logic [GW-1:0]   gnt_idx;
   logic            gnt_found;
   logic [CW-1:0]   cnt;

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!gnt_found && req_valid[(int'(last) + k) % NREQ]) begin
            gnt_found = 1'b1;
            gnt_idx   = GW'((int'(last) + k) % NREQ);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      busy      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (en && gnt_found && !rst) begin
               req_ready = NREQ'(1) << gnt_idx;
               state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            busy = 1'b1;
            if (cnt == '0) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // lut_a is held between evaluations; lut_spo is a SETTLE-cycle multicycle path.
   always_ff @(posedge clk) begin
      if (rst) begin
         lut_a     <= '0;
         rsp_valid <= '0;
         rsp_goe   <= 2'b00;
         grant_id  <= '0;
         last      <= GW'(NREQ - 1);
         cnt       <= '0;
      end else begin
         rsp_valid <= '0;
         if (|req_ready) begin
            lut_a    <= req_mask[gnt_idx*256 +: 256];
            grant_id <= gnt_idx;
            last     <= gnt_idx;
            cnt      <= CW'(S_EFF - 1);
         end
         if (state == ST_SETTLE) begin
            if (cnt == '0) begin
               rsp_goe   <= lut_spo;
               rsp_valid <= NREQ'(1) << grant_id;
            end else begin
               cnt <= cnt - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_goe_eval_sched.sv
// Directed bench for goe_eval_sched: cycle-level protocol model plus hand-computed checks.
module tb_goe_eval_sched;

   localparam int NREQ = 2;
   localparam int S    = 2;

   logic           clk = 1'b0;
   logic           rst, en;
   logic [1:0]     rv, rdy, rspv, goe, spo, spo_force;
   logic [511:0]   rmask;
   logic [255:0]   luta;
   logic           busy, ovr;
   logic [0:0]     gid;

   logic           en1;
   logic [0:0]     rv1, rdy1, rspv1, gid1;
   logic [255:0]   rmask1, luta1;
   logic [1:0]     goe1, spo1;
   logic           busy1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Stand-in for the LUT tree: bit1 = any pixel set, bit0 = parity of upper half.
   function automatic logic [1:0] lut_fn(input logic [255:0] a);
      return {|a, ^a[255:128]};
   endfunction

   assign spo  = ovr ? spo_force : lut_fn(luta);
   assign spo1 = lut_fn(luta1);

   goe_eval_sched #(.NREQ(NREQ), .SETTLE(S)) u_dut (
      .clk(clk), .rst(rst), .en(en), .req_valid(rv), .req_mask(rmask),
      .req_ready(rdy), .rsp_valid(rspv), .rsp_goe(goe), .lut_a(luta),
      .lut_spo(spo), .busy(busy), .grant_id(gid)
   );

   goe_eval_sched #(.NREQ(1), .SETTLE(0)) u_s0 (
      .clk(clk), .rst(rst), .en(en1), .req_valid(rv1), .req_mask(rmask1),
      .req_ready(rdy1), .rsp_valid(rspv1), .rsp_goe(goe1), .lut_a(luta1),
      .lut_spo(spo1), .busy(busy1), .grant_id(gid1)
   );

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Protocol model: tracks the accept cycle and derives busy/result timing from it.
   initial begin
      int         c, m_acc, m_last, m_gid, g;
      bit         m_inflight, found;
      logic [255:0] m_lut_a;
      logic [1:0] m_rspv, m_goe, rdy_e;
      c = 0; m_acc = 0; m_last = NREQ - 1; m_gid = 0;
      m_inflight = 0; m_lut_a = '0; m_rspv = '0; m_goe = '0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         found = 0; g = 0; rdy_e = '0;
         if (!rst && !m_inflight && en) begin
            for (int k = 1; k <= NREQ; k++) begin
               if (!found && rv[(m_last + k) % NREQ]) begin
                  found = 1;
                  g = (m_last + k) % NREQ;
               end
            end
            if (found) rdy_e = 2'(1 << g);
         end
         chk("m_req_ready", rdy, rdy_e);
         chk("m_busy", busy, m_inflight);
         chk("m_rsp_valid", rspv, m_rspv);
         chk("m_rsp_goe", goe, m_goe);
         chk("m_lut_a", luta, m_lut_a);
         chk("m_grant_id", gid, m_gid);
         if (rst) begin
            m_inflight = 0; m_last = NREQ - 1; m_gid = 0;
            m_lut_a = '0; m_rspv = '0; m_goe = '0;
         end else begin
            m_rspv = '0;
            if (m_inflight && c == m_acc + S) begin
               m_rspv = 2'(1 << m_gid);
               m_goe = ovr ? spo_force : lut_fn(m_lut_a);
               m_inflight = 0;
            end else if (found) begin
               m_inflight = 1;
               m_acc = c;
               m_gid = g;
               m_last = g;
               m_lut_a = rmask[g*256 +: 256];
            end
         end
         c++;
      end
   end

   initial begin
      rst = 1; en = 0; rv = '0; rmask = '0; ovr = 0; spo_force = '0;
      en1 = 0; rv1 = '0; rmask1 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", rdy, 2'b00);
      chk("rst_rsp_valid", rspv, 2'b00);
      chk("rst_goe", goe, 2'b00);
      chk("rst_lut_a", luta, 256'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_grant_id", gid, 1'b0);
      chk("s0_rst_lut_a", luta1, 256'h0);
      chk("s0_rst_busy", busy1, 1'b0);
      tick(); rst = 0;

      // Single request; SETTLE=0 instance runs the same handshake alongside.
      tick();
      en = 1; rv = 2'b01; rmask[255:0] = 256'h1;
      en1 = 1; rv1 = 1'b1; rmask1 = 256'h1 << 200;
      @(negedge clk);
      chk("t1_ready", rdy, 2'b01);
      chk("s0_ready", rdy1, 1'b1);
      tick(); rv = '0; rv1 = '0;
      @(negedge clk);
      chk("t1_lut_a", luta, 256'h1);
      chk("t1_busy1", busy, 1'b1);
      chk("t1_norsp1", rspv, 2'b00);
      chk("s0_busy", busy1, 1'b1);
      chk("s0_norsp", rspv1, 1'b0);
      chk("s0_lut_a", luta1, 256'h1 << 200);
      tick();
      @(negedge clk);
      chk("t1_busy2", busy, 1'b1);
      chk("t1_norsp2", rspv, 2'b00);
      chk("s0_rsp", rspv1, 1'b1);
      chk("s0_goe", goe1, 2'b11);
      chk("s0_idle", busy1, 1'b0);
      tick();
      @(negedge clk);
      chk("t1_rsp", rspv, 2'b01);
      chk("t1_goe", goe, 2'b10);
      chk("t1_idle", busy, 1'b0);
      chk("s0_rsp_clr", rspv1, 1'b0);

      // Both requesters continuously valid: grants every 3 cycles alternating.
      tick(); rst = 1;
      tick(); rst = 0; rv = 2'b11;
      rmask[255:0] = 256'hA5A5; rmask[511:256] = (256'h1 << 255) | 256'h3;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("rr_ready", rdy, (i % 3 == 0) ? (((i / 3) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00);
         tick();
      end
      rv = '0;
      repeat (4) tick();

      // lut_spo changes mid-settle; the last settle cycle's value is captured.
      rv = 2'b01; rmask[255:0] = 256'hF0;
      @(negedge clk);
      chk("spo_ready", rdy, 2'b01);
      tick(); rv = '0; ovr = 1; spo_force = 2'b01;
      tick(); spo_force = 2'b11;
      tick(); ovr = 0;
      @(negedge clk);
      chk("spo_rsp", rspv, 2'b01);
      chk("spo_goe", goe, 2'b11);

      // en low blocks grants; en dropped during settle does not stop completion.
      tick(); rst = 1; en = 0; rv = 2'b11;
      tick(); rst = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("en_low_ready", rdy, 2'b00);
         tick();
      end
      en = 1;
      @(negedge clk);
      chk("en_high_ready", rdy, 2'b01);
      tick(); en = 0; rv = '0;
      @(negedge clk);
      chk("en_drop_busy", busy, 1'b1);
      tick();
      tick();
      @(negedge clk);
      chk("en_drop_rsp", rspv, 2'b01);
      chk("en_drop_goe", goe, 2'b10);

      // Reset during settle aborts the evaluation.
      tick(); en = 1; rv = 2'b10; rmask[511:256] = 256'hBEEF;
      @(negedge clk);
      chk("abort_ready", rdy, 2'b10);
      tick(); rv = '0; rst = 1;
      @(negedge clk);
      chk("abort_lut_a_pre", luta, 256'hBEEF);
      tick(); rst = 0;
      @(negedge clk);
      chk("abort_lut_a", luta, 256'h0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_gid", gid, 1'b0);
      chk("abort_rsp", rspv, 2'b00);
      chk("abort_goe", goe, 2'b00);
      tick(); rv = 2'b11;
      @(negedge clk);
      chk("abort_next_ready", rdy, 2'b01);
      chk("abort_no_rsp", rspv, 2'b00);
      tick(); rv = '0;
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
